// File: rtl/burst_ram_pro.sv
// Avalon-MM style burst RAM model: byte-enabled burst writes and burst reads.
// Read beats start one clock after accept (N+1 busy clocks); BURST_RAM_STALL_EN inserts LFSR stalls.
// oWaitrequest is high for a whole read burst; a write burst keeps it low and pauses on iWrite=0.
module burst_ram_pro #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 24,
  parameter int BURST_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iRead,
  input  logic [ADDR_W-1:0]     iAddress,
  input  logic [BURST_W-1:0]    iBurstcount,
  input  logic                  iWrite,
  input  logic [ADDR_W-1:0]     iWriteaddress,
  input  logic [DATA_W-1:0]     iWritedata,
  input  logic [DATA_W/8-1:0]   iByteenable,
  output logic [DATA_W-1:0]     oData,
  output logic                  oDatavalid,
  output logic                  oWaitrequest
);

  localparam int BE_W    = DATA_W / 8;
  localparam int BYTE_SH = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t               state;
  logic [DATA_W-1:0]    mem [0:(2**DEPTH_W)-1];
  logic [DEPTH_W-1:0]   rdAddr;
  logic [DEPTH_W-1:0]   wrAddr;
  logic [BURST_W-1:0]   rdCnt;
  logic [BURST_W-1:0]   wrCnt;
  logic [ADDR_W-1:0]    rdShift;
  logic [ADDR_W-1:0]    wrShift;
  logic [DEPTH_W-1:0]   rdIdx;
  logic [DEPTH_W-1:0]   wrIdx;
  logic [DEPTH_W-1:0]   memWaddr;
  logic [BURST_W-1:0]   cmdLen;
  logic                 wrAccept;
  logic                 rdAccept;
  logic                 memWe;
  logic                 beatStall;
  logic                 unusedAddrBits;

  assign rdShift        = iAddress >> BYTE_SH;
  assign wrShift        = iWriteaddress >> BYTE_SH;
  assign rdIdx          = rdShift[DEPTH_W-1:0];
  assign wrIdx          = wrShift[DEPTH_W-1:0];
  assign unusedAddrBits = ^{rdShift[ADDR_W-1:DEPTH_W], wrShift[ADDR_W-1:DEPTH_W]};

  assign cmdLen   = (iBurstcount == '0) ? BURST_W'(1) : iBurstcount;
  // Write wins a simultaneous request; the read stays pending on the bus.
  assign wrAccept = (state == IDLE) && iWrite && !oWaitrequest;
  assign rdAccept = (state == IDLE) && iRead && !iWrite && !oWaitrequest;
  assign memWe    = reset_n && (wrAccept || ((state == WR_BURST) && iWrite));
  assign memWaddr = (state == IDLE) ? wrIdx : wrAddr;

`ifdef BURST_RAM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign beatStall = lfsr[0];
`else
  assign beatStall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < BE_W; b++) begin
        if (iByteenable[b]) begin
          mem[memWaddr][b*8 +: 8] <= iWritedata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      oData        <= '0;
      oDatavalid   <= 1'b0;
      oWaitrequest <= 1'b0;
      rdAddr       <= '0;
      wrAddr       <= '0;
      rdCnt        <= '0;
      wrCnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDatavalid <= 1'b0;
          if (wrAccept) begin
            wrAddr <= wrIdx + DEPTH_W'(1);
            wrCnt  <= cmdLen - BURST_W'(1);
            if (cmdLen != BURST_W'(1)) begin
              state <= WR_BURST;
            end
          end else if (rdAccept) begin
            rdAddr       <= rdIdx;
            rdCnt        <= cmdLen;
            oWaitrequest <= 1'b1;
            state        <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (rdCnt == '0) begin
            oDatavalid   <= 1'b0;
            oWaitrequest <= 1'b0;
            state        <= IDLE;
          end else if (beatStall) begin
            oDatavalid <= 1'b0;
          end else begin
            oData      <= mem[rdAddr];
            oDatavalid <= 1'b1;
            rdAddr     <= rdAddr + DEPTH_W'(1);
            rdCnt      <= rdCnt - BURST_W'(1);
          end
        end
        WR_BURST: begin
          oDatavalid <= 1'b0;
          if (iWrite) begin
            wrAddr <= wrAddr + DEPTH_W'(1);
            wrCnt  <= wrCnt - BURST_W'(1);
            if (wrCnt == BURST_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
